// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, states and default latencies for the MD unit
package mdu_pkg;

  // MD operation codes as presented by the E stage
  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MTHI  = 4'd4,
    MDU_MTLO  = 4'd5,
    MDU_MADD  = 4'd6,
    MDU_MADDU = 4'd7,
    MDU_MSUB  = 4'd8,
    MDU_MSUBU = 4'd9
  } mdu_op_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath; MADD/MSUB family enabled by MDU_MADD_EN
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic [31:0] w_den_s;
  logic [31:0] w_den_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  // Products on 64-bit operands; sign extension gives the signed result in the low 64 bits
  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // Signed divide done on magnitudes so truncation toward zero and -2^31 / -1 are well defined
  assign w_rs_neg = i_rs[31];
  assign w_rt_neg = i_rt[31];
  assign w_rs_abs = w_rs_neg ? (32'd0 - i_rs) : i_rs;
  assign w_rt_abs = w_rt_neg ? (32'd0 - i_rt) : i_rt;
  // A zero divisor is replaced by 1 only to keep the datapath X-free; its result is discarded
  assign w_den_s  = (w_rt_abs == 32'd0) ? 32'd1 : w_rt_abs;
  assign w_den_u  = (i_rt == 32'd0) ? 32'd1 : i_rt;
  assign w_q_mag  = w_rs_abs / w_den_s;
  assign w_r_mag  = w_rs_abs % w_den_s;
  assign w_q_s    = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s    = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_q_u    = i_rs / w_den_u;
  assign w_r_u    = i_rs % w_den_u;

  assign o_div_zero = ((i_op == MDU_DIV) || (i_op == MDU_DIVU)) && (i_rt == 32'd0);

  // Select the {hi,lo} result for the requested operation
  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
      MDU_DIV:   o_result = {w_r_s, w_q_s};
      MDU_DIVU:  o_result = {w_r_u, w_q_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
      MDU_MADDU: o_result = {i_hi, i_lo} + w_prod_u;
      MDU_MSUB:  o_result = {i_hi, i_lo} - w_prod_s;
      MDU_MSUBU: o_result = {i_hi, i_lo} - w_prod_u;
`endif
      default:   o_result = 64'd0;
    endcase
  end

`ifndef MDU_MADD_EN
  logic w_unused_hilo;
  assign w_unused_hilo = ^{i_hi, i_lo};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MD unit sequencer with HI/LO registers; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_pend;
  logic        r_div_zero;

  mdu_state_e  w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] w_pend_nxt;
  logic        w_div_zero_nxt;

  logic [63:0] w_result;
  logic        w_div_zero;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_start_mul_div;
  logic        w_accept;

  mdu_arith u_arith (
    .i_op       (op),
    .i_rs       (rs_val),
    .i_rt       (rt_val),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

`ifdef MDU_MADD_EN
  assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU) ||
                    (op == MDU_MADD) || (op == MDU_MADDU) ||
                    (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
  assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);

  assign w_start_mul_div = start & (w_is_mul | w_is_div);
  // A flushed instruction or one arriving while busy never reaches HI/LO
  assign w_accept        = start & ~req & (r_state == ST_IDLE);

  assign busy     = (r_state == ST_RUN);
  assign md_stall = w_start_mul_div | busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Next-state, counter and HI/LO update logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_pend_nxt     = r_pend;
    w_div_zero_nxt = r_div_zero;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_pend_nxt     = w_result;
            w_div_zero_nxt = 1'b0;
            w_cnt_nxt      = LP_MULT_CNT;
            w_state_nxt    = ST_RUN;
          end else if (w_is_div) begin
            w_pend_nxt     = w_result;
            w_div_zero_nxt = w_div_zero;
            w_cnt_nxt      = LP_DIV_CNT;
            w_state_nxt    = ST_RUN;
          end else if (op == MDU_MTHI) begin
            w_hi_nxt = rs_val;
          end else if (op == MDU_MTLO) begin
            w_lo_nxt = rs_val;
          end
        end
      end
      ST_RUN: begin
        // Commit on the last busy cycle; a zero-divisor divide leaves HI/LO alone
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
          if (!r_div_zero) begin
            w_hi_nxt = r_pend[63:32];
            w_lo_nxt = r_pend[31:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and register file update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_pend     <= 64'd0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_pend     <= w_pend_nxt;
      r_div_zero <= w_div_zero_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl; MDU_MADD_EN selects the MADD vectors
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .req      (req),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns md_stall seen in that cycle
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r, output logic stall);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    req    = r;
    #1 stall = md_stall;
    @(negedge clk);
    start = 1'b0;
    req   = 1'b0;
  endtask

  // Count busy cycles, optionally pulsing req during busy cycle index req_at
  task automatic count_busy(input int req_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      req = (n == req_at);
      n++;
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic st;
    int   n;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    rs_val  = 32'd0;
    rt_val  = 32'd0;
    req     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_stall", {63'd0, md_stall}, 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;

    issue(MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, st);
    check_eq("mult_stall", {63'd0, st}, 64'd1);
    count_busy(-1, n);
    check_eq("mult_busy_cycles", n, 64'd5);
    check_eq("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0, st);
    count_busy(-1, n);
    check_eq("divu_busy_cycles", n, 64'd10);
    check_eq("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, st);
    count_busy(-1, n);
    check_eq("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, st);
    count_busy(-1, n);
    check_eq("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, st);
    check_eq("mthi_stall", {63'd0, st}, 64'd0);
    issue(MDU_MTLO, 32'h22, 32'd0, 1'b0, st);
    check_eq("mt_busy", {63'd0, busy}, 64'd0);
    check_eq("mt_hilo", {hi, lo}, {32'h11, 32'h22});

    issue(MDU_DIV, 32'd55, 32'd0, 1'b0, st);
    count_busy(-1, n);
    check_eq("divzero_busy_cycles", n, 64'd10);
    check_eq("divzero_hilo", {hi, lo}, {32'h11, 32'h22});

    issue(MDU_MULT, 32'd9, 32'd9, 1'b1, st);
    check_eq("mult_req_busy", {63'd0, busy}, 64'd0);
    check_eq("mult_req_hilo", {hi, lo}, {32'h11, 32'h22});

    issue(MDU_MTLO, 32'h99, 32'd0, 1'b1, st);
    check_eq("mtlo_req_hilo", {hi, lo}, {32'h11, 32'h22});

    issue(MDU_MULT, 32'd6, 32'd7, 1'b0, st);
    count_busy(2, n);
    check_eq("mult_req_run_cycles", n, 64'd5);
    check_eq("mult_req_run_hilo", {hi, lo}, {32'd0, 32'd42});

    issue(MDU_MTLO, 32'hDEADBEEF, 32'd0, 1'b0, st);
    check_eq("mtlo_busy", {63'd0, busy}, 64'd0);
    check_eq("mtlo_lo", {32'd0, lo}, 64'hDEADBEEF);

    issue(MDU_DIVU, 32'd9, 32'd2, 1'b0, st);
    start  = 1'b1;
    op     = MDU_MTHI;
    rs_val = 32'h55;
    #1 check_eq("busy_stall", {63'd0, md_stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    count_busy(-1, n);
    check_eq("divu_ignore_cycles", n, 64'd9);
    check_eq("divu_ignore_hilo", {hi, lo}, {32'd1, 32'd4});

    issue(MDU_DIV, 32'd50, 32'd5, 1'b0, st);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrun_reset_busy", {63'd0, busy}, 64'd0);
    check_eq("midrun_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("after_reset_busy", {63'd0, busy}, 64'd0);

    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, st);
    issue(MDU_MTLO, 32'd10, 32'd0, 1'b0, st);
    issue(MDU_MADD, 32'd3, 32'd4, 1'b0, st);
    count_busy(-1, n);
`ifdef MDU_MADD_EN
    check_eq("madd_cycles", n, 64'd5);
    check_eq("madd_hilo", {hi, lo}, {32'd0, 32'd22});
`else
    check_eq("madd_off_cycles", n, 64'd0);
    check_eq("madd_off_hilo", {hi, lo}, {32'd0, 32'd10});
`endif

    issue(4'hF, 32'd5, 32'd5, 1'b0, st);
    check_eq("unknown_stall", {63'd0, st}, 64'd0);
    check_eq("unknown_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
